// File: rtl/red_pitaya_sort_pulser.sv
// Sort-trigger to bipolar square-wave burst generator for the HV sorting amplifier DAC.
// Define SORT_PULSER_TIMESTAMP_EN to add a trigger timestamp (0x10C latched, 0x110 live).
module red_pitaya_sort_pulser #(
  parameter int DWD = 14,
  parameter int MEM = 32
) (
  input  logic           adc_clk_i,
  input  logic           adc_rst_i,
  input  logic           sort_trig_i,
  output logic [DWD-1:0] dac_o,
  output logic           busy_o,
  input  logic [31:0]    sys_addr,
  input  logic [31:0]    sys_wdata,
  input  logic [3:0]     sys_sel,
  input  logic           sys_wen,
  input  logic           sys_ren,
  output logic [31:0]    sys_rdata,
  output logic           sys_err,
  output logic           sys_ack
);

  localparam int AW = DWD - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]  amp_q;
  logic [MEM-1:0] half_q, hold_q;
  logic [15:0]    ncyc_q;
  logic           en_q, inv_q;
  logic           sort_trig_q, sw_trig_q;

  logic [MEM-1:0] half_s_q, half_s_d;
  logic [15:0]    ncyc_s_q, ncyc_s_d;
  logic [MEM-1:0] cnt_q, cnt_d;
  logic [16:0]    hc_q, hc_d;
  logic           phase_q, phase_d;
  logic [DWD-1:0] dac_q, dac_d;
  logic           busy_q;
  logic [MEM-1:0] bursts_q, bursts_d, dropped_q, dropped_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           ack_q;

  logic [19:0]    addr;
  logic           ctrl_wr, en_eff, trig;
  logic [MEM-1:0] half_eff;
  logic [DWD-1:0] pos_lvl, neg_lvl;
  logic           boundary, burst_end;
  logic           unused_bits;

  assign addr        = sys_addr[19:0];
  assign unused_bits = ^{sys_sel, sys_addr[31:20]};
  assign ctrl_wr     = sys_wen && (addr == 20'h00010);
  // A control write clearing enable stops the FSM at the same edge it lands.
  assign en_eff      = ctrl_wr ? sys_wdata[0] : en_q;
  assign trig        = (sort_trig_i & ~sort_trig_q) | sw_trig_q;
  assign half_eff    = (half_s_q == '0) ? MEM'(1) : half_s_q;
  assign pos_lvl     = DWD'(amp_q);
  assign neg_lvl     = '0 - pos_lvl;
  assign boundary    = (cnt_q == half_eff - MEM'(1));
  // Gated mode stops only at a full period boundary (end of the second half).
  assign burst_end   = (ncyc_s_q != '0) ? ((hc_q + 17'd1) == {ncyc_s_q, 1'b0})
                                        : (phase_q && !sort_trig_i);

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      amp_q       <= AW'(4096);
      half_q      <= MEM'(12500);
      ncyc_q      <= 16'd10;
      hold_q      <= MEM'(1250);
      en_q        <= 1'b1;
      inv_q       <= 1'b0;
      sort_trig_q <= 1'b0;
      sw_trig_q   <= 1'b0;
    end else begin
      sort_trig_q <= sort_trig_i;
      sw_trig_q   <= ctrl_wr && sys_wdata[1];
      if (sys_wen) begin
        case (addr)
          20'h00000: amp_q  <= sys_wdata[AW-1:0];
          20'h00004: half_q <= sys_wdata[MEM-1:0];
          20'h00008: ncyc_q <= sys_wdata[15:0];
          20'h0000C: hold_q <= sys_wdata[MEM-1:0];
          20'h00010: begin
            en_q  <= sys_wdata[0];
            inv_q <= sys_wdata[2];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dac_d     = dac_q;
    cnt_d     = cnt_q;
    hc_d      = hc_q;
    phase_d   = phase_q;
    half_s_d  = half_s_q;
    ncyc_s_d  = ncyc_s_q;
    bursts_d  = bursts_q;
    dropped_d = dropped_q;
    unique case (state_q)
      IDLE: begin
        dac_d = '0;
        if (trig && en_eff) begin
          state_d  = BURST;
          cnt_d    = '0;
          hc_d     = '0;
          phase_d  = 1'b0;
          half_s_d = half_q;
          ncyc_s_d = ncyc_q;
          dac_d    = inv_q ? neg_lvl : pos_lvl;
        end
      end
      BURST: begin
        if (trig) dropped_d = dropped_q + MEM'(1);
        if (!en_eff) begin
          state_d = IDLE;
          dac_d   = '0;
        end else if (boundary) begin
          cnt_d = '0;
          if (burst_end) begin
            state_d  = HOLDOFF;
            dac_d    = '0;
            bursts_d = bursts_q + MEM'(1);
          end else begin
            hc_d     = hc_q + 17'd1;
            phase_d  = ~phase_q;
            half_s_d = half_q;
            ncyc_s_d = ncyc_q;
            dac_d    = (~phase_q ^ inv_q) ? neg_lvl : pos_lvl;
          end
        end else begin
          cnt_d = cnt_q + MEM'(1);
        end
      end
      HOLDOFF: begin
        dac_d = '0;
        if (trig) dropped_d = dropped_q + MEM'(1);
        if (!en_eff || (cnt_q + MEM'(1) >= hold_q)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + MEM'(1);
        end
      end
      default: begin
        state_d = IDLE;
        dac_d   = '0;
      end
    endcase
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      dac_q     <= '0;
      cnt_q     <= '0;
      hc_q      <= '0;
      phase_q   <= 1'b0;
      half_s_q  <= '0;
      ncyc_s_q  <= '0;
      bursts_q  <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != IDLE);
      dac_q     <= dac_d;
      cnt_q     <= cnt_d;
      hc_q      <= hc_d;
      phase_q   <= phase_d;
      half_s_q  <= half_s_d;
      ncyc_s_q  <= ncyc_s_d;
      bursts_q  <= bursts_d;
      dropped_q <= dropped_d;
    end
  end

`ifdef SORT_PULSER_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_lat_q;

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      ts_cnt_q <= '0;
      ts_lat_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if ((state_q == IDLE) && trig && en_eff) ts_lat_q <= ts_cnt_q;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (addr)
      20'h00000: rdata_d = 32'(amp_q);
      20'h00004: rdata_d = 32'(half_q);
      20'h00008: rdata_d = 32'(ncyc_q);
      20'h0000C: rdata_d = 32'(hold_q);
      20'h00010: rdata_d = {29'd0, inv_q, 1'b0, en_q};
      20'h00100: rdata_d = 32'(bursts_q);
      20'h00104: rdata_d = 32'(dropped_q);
      20'h00108: rdata_d = {30'd0, state_q};
`ifdef SORT_PULSER_TIMESTAMP_EN
      20'h0010C: rdata_d = ts_lat_q;
      20'h00110: rdata_d = ts_cnt_q;
`endif
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= sys_wen | sys_ren;
      if (sys_ren) rdata_q <= rdata_d;
    end
  end

  assign dac_o     = dac_q;
  assign busy_o    = busy_q;
  assign sys_rdata = rdata_q;
  assign sys_ack   = ack_q;
  assign sys_err   = 1'b0;

endmodule

// File: doc/red_pitaya_sort_pulser.md
Name: red_pitaya_sort_pulser

Overview:
Consumer end of the FADS sort trigger. Converts the sort trigger level into a bipolar square-wave burst on a 14-bit DAC channel, which feeds the external high-voltage amplifier driving the sorting electrodes. Amplitude, frequency, burst length and hold-off are configured over the system bus. The block keeps burst and dropped-trigger counters for diagnostics.

Parameters:
DWD, 14, DAC data width (two's complement)
MEM, 32, width of timing/counter registers

Ports:
adc_clk_i  input  1  ADC clock (125 MHz), sole clock
adc_rst_i  input  1  asynchronous active-high reset
sort_trig_i  input  1  sort trigger level from FADS detector
dac_o  output  DWD  signed DAC sample to HV amplifier
busy_o  output  1  high in BURST or HOLDOFF
sys_addr  input  32  bus address
sys_wdata  input  32  bus write data
sys_sel  input  4  byte select (ignored, full-word writes only)
sys_wen  input  1  bus write enable
sys_ren  input  1  bus read enable
sys_rdata  output  32  bus read data
sys_err  output  1  bus error, always 0
sys_ack  output  1  bus acknowledge

Behaviour:
- One clock (adc_clk_i); reset asynchronous, active-high (adc_rst_i). All regs asynchronously reset.
- Reset values: dac_o=0, busy_o=0, sys_ack=0, sys_err=0, sys_rdata=0, state=IDLE, counters=0.
- Register map (sys_addr[19:0]):
  - 0x00 amplitude, 13b unsigned. Reset 0x1000.
  - 0x04 half_period, 32b, in cycles. Reset 12500. A value of 0 is treated as 1.
  - 0x08 n_cycles, 16b. Reset 10. A value of 0 selects gated mode.
  - 0x0C holdoff, 32b, in cycles. Reset 1250.
  - 0x10 control: bit0 enable (reset 1); bit1 sw_trig (write-1 pulse, always reads 0); bit2 invert (reset 0).
  - 0x100 bursts_done (RO). 0x104 trig_dropped (RO). 0x108 state code (RO): IDLE=0, BURST=1, HOLDOFF=2.
- Bus timing:
  - sys_ack <= sys_en (= sys_wen|sys_ren) one cycle after the request, for every address.
  - Reads of unmapped addresses return 0. Writes to RO or unmapped addresses are ignored.
- Trigger: trig = (sort_trig_i & ~sort_trig_q) | sw_trig_pulse, where sort_trig_q is sort_trig_i registered once.
  - A simultaneous hw edge and sw_trig counts as one trigger.
- IDLE:
  - dac_o=0.
  - On trig with enable=1, go to BURST. dac_o=+amplitude from the next cycle (-amplitude if invert=1).
  - On trig with enable=0, ignore; not counted.
- BURST:
  - dac_o holds each level for half_period cycles, then negates. Half-period counter starts at 0.
  - Count mode (n_cycles>0): after 2*n_cycles half-periods, dac_o=0 and go to HOLDOFF.
  - Gated mode (n_cycles=0): continue while sort_trig_i=1. When it is 0 at the end of a negative half-period (a full period boundary), go to HOLDOFF.
  - trig during BURST: trig_dropped+1, no other effect.
- HOLDOFF:
  - dac_o=0 for holdoff cycles, then IDLE. holdoff=0 means return to IDLE on the next cycle.
  - bursts_done+1 on entry to HOLDOFF.
  - trig during HOLDOFF: trig_dropped+1.
- Enable cleared mid-burst or mid-holdoff: next cycle go to IDLE with dac_o=0. bursts_done is not incremented.
- Config writes during BURST take effect at the next half-period boundary. Writes are latched into shadow registers at each boundary and at burst start.
- Counters wrap at 2^32 - 1 -> 0.
- Negation: -amplitude is formed in DWD bits. Amplitude ≤ 8191 guarantees no overflow.
- busy_o = (state != IDLE), registered alongside the state.

Optional Feature:
SORT_PULSER_TIMESTAMP_EN:
- Defined: a free-running 32b cycle counter is added, reset 0, wrapping. Its value is latched on every accepted trigger (IDLE->BURST). The latched value reads at 0x10C; the live counter reads at 0x110.
- Undefined: no counter is built, and 0x10C/0x110 read 0 like any unmapped address.

Test Plan:
1. Reset, write amplitude=100, half_period=4, n_cycles=2, holdoff=3; pulse sort_trig_i high for 1 cycle at cycle N -> dac_o = +100 for cycles N+1..N+4, -100 for N+5..N+8, +100 for N+9..N+12, -100 for N+13..N+16, 0 from N+17. busy_o falls at N+20. bursts_done=1.
2. Gated mode: n_cycles=0, half_period=2, sort_trig_i high for 9 cycles -> 3 full periods (12 cycles of output), ends on a -amplitude half, then HOLDOFF.
3. Second sort_trig_i edge during BURST and another during HOLDOFF -> trig_dropped=2, bursts_done=1, waveform unchanged.
4. Write control=0 midway through a burst -> dac_o=0 and state=0 on the next cycle, bursts_done unchanged. A subsequent hw edge is ignored and trig_dropped stays unchanged.
5. invert=1, sw_trig via write 0x10=0x7 -> first half-period = -amplitude. sys_ack is high exactly one cycle after the write; reading 0x10 returns 0x5.
6. Assert adc_rst_i asynchronously mid-burst -> dac_o=0, busy_o=0, all registers back to reset values immediately, without waiting for a clock edge.
